// File: rtl/clk_div_ctrl_if.sv
// Run/config/status bundle for the board clock divider controller.
interface clk_div_ctrl_if #(
  parameter int CNT_W = 20
);
  logic             run;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic             cfg_err;

  modport master (
    output run, cfg_valid, cfg_half,
    input  cfg_ready, clk_out, tick, busy, cfg_err
  );

  modport slave (
    input  run, cfg_valid, cfg_half,
    output cfg_ready, clk_out, tick, busy, cfg_err
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time clock divider controller: produces a square wave of period
// 2*half_reg input clocks, with ratio changes and stops applied only on
// period boundaries so clk_out never produces a runt pulse.
//
// state | meaning
// IDLE  | clk_out held low, counter cleared; config loads half_reg directly
// RUN   | generating periods; config is held pending until the next boundary
// STOP  | run dropped; finish the current period, then go IDLE at the boundary
module clk_div_ctrl #(
  parameter int CNT_W        = 20,
  parameter int DEFAULT_HALF = 250000
) (
  input  logic           clk_50MHz,
  input  logic           reset,
  clk_div_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_half_q, pend_half_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             xfer;
  logic             legal;
  logic             last;
  logic             boundary;

  // A zero half-period is consumed but never stored.
  assign xfer     = bus.cfg_valid && !pend_q;
  assign legal    = xfer && (bus.cfg_half != '0);
  // half_q is never zero, so half_q-1 cannot wrap.
  assign last     = (cnt_q == (half_q - CNT_W'(1)));
  // Boundary: the cycle in which clk_out would rise.
  assign boundary = last && !clk_q;

  assign bus.cfg_ready = !pend_q;
  assign bus.clk_out   = clk_q;
  assign bus.tick      = tick_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.cfg_err   = err_q;

  // Next-state, counter, config and output decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    pend_d      = pend_q;
    pend_half_d = pend_half_q;
    clk_d       = clk_q;
    tick_d      = 1'b0;
    err_d       = xfer && (bus.cfg_half == '0);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        // A value latched at the final STOP boundary lands here; otherwise
        // a fresh legal value loads straight in and governs the first period.
        if (pend_q) begin
          half_d = pend_half_q;
          pend_d = 1'b0;
        end else if (legal) begin
          half_d = bus.cfg_half;
        end
        if (bus.run) begin
          state_d = RUN;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end

      RUN, STOP: begin
        // Only possible while nothing is pending, so it never collides
        // with the boundary apply below.
        if (legal) begin
          pend_d      = 1'b1;
          pend_half_d = bus.cfg_half;
        end
        if (boundary && pend_q) begin
          half_d = pend_half_q;
          pend_d = 1'b0;
        end

        if (last) begin
          cnt_d = '0;
          clk_d = !clk_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        state_d = bus.run ? RUN : STOP;

        if (boundary) begin
          if ((state_q == STOP) && !bus.run) begin
            state_d = IDLE;
            clk_d   = 1'b0;
          end else begin
            tick_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      half_q      <= DEF_HALF;
      pend_half_q <= '0;
      pend_q      <= 1'b0;
      clk_q       <= 1'b0;
      tick_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      pend_half_q <= pend_half_d;
      pend_q      <= pend_d;
      clk_q       <= clk_d;
      tick_q      <= tick_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed vector table, multi-cycle corner
// sequences and randomized traffic against a period-queue reference model.
module tb_clk_div_ctrl;
  localparam int CNT_W = 20;
  localparam int DEF   = 4;

  logic clk;
  logic rst;

  clk_div_ctrl_if #(.CNT_W(CNT_W)) bus ();

  clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(DEF)) dut (
    .clk_50MHz (clk),
    .reset     (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int ticks[$];

  // Reference model: each period is pre-expanded into a queue of clk_out
  // levels; an empty queue at an edge means that edge is a period boundary.
  bit m_q[$];
  bit m_active;
  bit m_armed;
  int m_half;
  bit m_pend;
  int m_pend_half;
  bit m_clk, m_tick, m_err;

  task automatic start_period();
    for (int i = 0; i < m_half; i++) m_q.push_back(1'b1);
    for (int i = 0; i < m_half; i++) m_q.push_back(1'b0);
    m_clk  = m_q.pop_front();
    m_tick = 1'b1;
  endtask

  task automatic model_edge(input bit r, input bit rn, input bit v, input int h);
    bit xfer, legal;
    if (r) begin
      m_q.delete();
      m_active = 0; m_armed = 0; m_half = DEF; m_pend = 0; m_pend_half = 0;
      m_clk = 0; m_tick = 0; m_err = 0;
      return;
    end
    xfer   = v && !m_pend;
    legal  = xfer && (h != 0);
    m_err  = xfer && (h == 0);
    m_tick = 1'b0;
    if (!m_active) begin
      if (m_pend) begin m_half = m_pend_half; m_pend = 0; end
      else if (legal) m_half = h;
      if (rn) begin
        m_active = 1; m_armed = 0;
        start_period();
      end else begin
        m_clk = 0;
      end
    end else begin
      if (m_q.size() == 0) begin
        if (m_pend) begin m_half = m_pend_half; m_pend = 0; end
        else if (legal) begin m_pend = 1; m_pend_half = h; end
        if (m_armed && !rn) begin
          m_active = 0; m_clk = 0;
        end else begin
          start_period();
        end
      end else begin
        if (legal) begin m_pend = 1; m_pend_half = h; end
        m_clk = m_q.pop_front();
      end
      m_armed = !rn;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit rn, input bit v, input int h);
    rst           = r;
    bus.run       = rn;
    bus.cfg_valid = v;
    bus.cfg_half  = CNT_W'(h);
    @(posedge clk);
    model_edge(r, rn, v, h);
    #1;
    cyc++;
    chk("model_clk_out",   int'(bus.clk_out),   int'(m_clk));
    chk("model_tick",      int'(bus.tick),      int'(m_tick));
    chk("model_busy",      int'(bus.busy),      int'(m_active));
    chk("model_cfg_ready", int'(bus.cfg_ready), int'(!m_pend));
    chk("model_cfg_err",   int'(bus.cfg_err),   int'(m_err));
    if (bus.tick) ticks.push_back(cyc);
  endtask

  function automatic int gap(input int i);
    if (ticks.size() > i + 1) return ticks[i+1] - ticks[i];
    return -1;
  endfunction

  typedef struct {
    bit rst, run, valid;
    int half;
    bit e_clk, e_tick, e_busy, e_rdy, e_err;
  } vec_t;

  function automatic vec_t mk(bit r, bit rn, bit v, int h,
                              bit ec, bit et, bit eb, bit er, bit ee);
    vec_t t;
    t.rst = r; t.run = rn; t.valid = v; t.half = h;
    t.e_clk = ec; t.e_tick = et; t.e_busy = eb; t.e_rdy = er; t.e_err = ee;
    return t;
  endfunction

  vec_t tbl[$];
  int   busy_log[10];
  bit   r_run;

  initial begin
    rst = 1'b1; bus.run = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_half = '0;

    //            rst run v half  clk tick busy rdy err
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1,  1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 1, 1, 1, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].run, tbl[i].valid, tbl[i].half);
      chk($sformatf("vec%0d_clk_out", i),   int'(bus.clk_out),   int'(tbl[i].e_clk));
      chk($sformatf("vec%0d_tick", i),      int'(bus.tick),      int'(tbl[i].e_tick));
      chk($sformatf("vec%0d_busy", i),      int'(bus.busy),      int'(tbl[i].e_busy));
      chk($sformatf("vec%0d_cfg_ready", i), int'(bus.cfg_ready), int'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_cfg_err", i),   int'(bus.cfg_err),   int'(tbl[i].e_err));
    end

    // cfg_err in IDLE leaves half unchanged: period still 8.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    ticks.delete();
    for (int i = 0; i < 18; i++) step(0, 1, 0, 0);
    chk("err_keep_period", gap(0), 8);

    // Ratio change mid high phase: current period 8, then 4-cycle periods.
    step(1, 0, 0, 0);
    ticks.delete();
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 2);
    chk("midrun_ready_low", int'(bus.cfg_ready), 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
    chk("midrun_gap_old", gap(0), 8);
    chk("midrun_gap_new", gap(1), 4);
    chk("midrun_gap_new2", gap(2), 4);

    // Stop during high phase: finish high + full low, then IDLE, no extra tick.
    step(1, 0, 0, 0);
    ticks.delete();
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 0);
      busy_log[k] = int'(bus.busy);
    end
    chk("stop_busy_before_bnd", busy_log[4], 1);
    chk("stop_busy_after_bnd",  busy_log[5], 0);
    chk("stop_tick_count", ticks.size(), 1);
    chk("stop_clk_low", int'(bus.clk_out), 0);

    // Run dropped then reasserted before the boundary: no disturbance.
    step(1, 0, 0, 0);
    ticks.delete();
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
    chk("reassert_gap0", gap(0), 8);
    chk("reassert_gap1", gap(1), 8);

    // Reset mid low phase with a pending config: pending value discarded.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 2);
    chk("rst_pend_set", int'(bus.cfg_ready), 0);
    step(1, 0, 0, 0);
    chk("rst_clk_low",  int'(bus.clk_out), 0);
    chk("rst_ready",    int'(bus.cfg_ready), 1);
    chk("rst_busy",     int'(bus.busy), 0);
    ticks.delete();
    for (int i = 0; i < 17; i++) step(0, 1, 0, 0);
    chk("rst_default_period", gap(0), 2 * DEF);

    // Randomized traffic against the model.
    step(1, 0, 0, 0);
    r_run = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) r_run = !r_run;
      step(($urandom_range(0, 199) == 0),
           r_run,
           ($urandom_range(0, 5) == 0),
           int'($urandom_range(0, 5)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
